// File: rtl/regbank_pkg.sv
// Shared types for the register-bank arbiter: widths, FSM states, op encoding.
// No logic of its own; latency n/a.
// Backpressure n/a.
package regbank_pkg;

  localparam int DW   = 8;
  localparam int NREG = 4;
  localparam int AW   = 2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    READ  = 2'd2,
    RESP  = 2'd3
  } state_t;

  typedef enum logic {
    OP_READ  = 1'b0,
    OP_WRITE = 1'b1
  } op_t;

  function automatic logic [NREG-1:0] addr_onehot(input logic [AW-1:0] a);
    addr_onehot    = '0;
    addr_onehot[a] = 1'b1;
  endfunction

endpackage

// File: rtl/regbank_arbiter_rr_arbiter2.sv
// Two-way arbiter: round-robin on a last-grant pointer, or fixed priority to requester 0
// when REGBANK_ARB_FIXED_PRIO_EN is defined. Grant is combinational (0 cycles).
// Pointer advances only when upd is asserted with a request present.
module rr_arbiter2 (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       upd,
  output logic [1:0] gnt,
  output logic       gnt_id
);

`ifdef REGBANK_ARB_FIXED_PRIO_EN
  logic unused_ok;
  assign unused_ok = ^{clk, rst, upd};
  assign gnt_id    = ~req[0];
`else
  logic last;

  // Reset to "requester 1 granted last" so requester 0 wins the first tie.
  always_ff @(posedge clk) begin
    if (rst) begin
      last <= 1'b1;
    end else if (upd && (|req)) begin
      last <= gnt_id;
    end
  end

  assign gnt_id = (req == 2'b11) ? ~last : req[1];
`endif

  assign gnt = (|req) ? (gnt_id ? 2'b10 : 2'b01) : 2'b00;

endmodule

// File: rtl/regbank_arbiter.sv
// Shares the 4x8 load-register bank between two requesters (grant -> WRITE/READ -> RESP).
// Latency: response 2 cycles after acceptance; one op per 3 cycles.
// Backpressure: req_ready only in IDLE; fixed priority via REGBANK_ARB_FIXED_PRIO_EN.
module regbank_arbiter
  import regbank_pkg::*;
(
  input  logic [0:0]        clk,
  input  logic              rst,
  input  logic [1:0]        req_valid,
  output logic [1:0]        req_ready,
  input  logic [1:0]        req_we,
  input  logic [2*AW-1:0]   req_addr,
  input  logic [2*DW-1:0]   req_wdata,
  output logic [1:0]        rsp_valid,
  output logic [DW-1:0]     rsp_rdata,
  output logic [NREG-1:0]   rf_ld,
  output logic [DW-1:0]     rf_d,
  output logic [AW-1:0]     rf_sel,
  input  logic [DW-1:0]     rf_q
);

  state_t          state, state_nxt;
  logic [1:0]      gnt;
  logic            gnt_id;
  logic            grant;
  op_t             gnt_op;
  logic [AW-1:0]   gnt_addr;
  logic [DW-1:0]   gnt_wdata;
  logic [AW-1:0]   cur_addr;
  logic            cur_g;

  assign grant     = (state == IDLE) && !rst && (|req_valid);
  assign gnt_op    = op_t'(gnt_id ? req_we[1] : req_we[0]);
  assign gnt_addr  = gnt_id ? req_addr[AW +: AW] : req_addr[0 +: AW];
  assign gnt_wdata = gnt_id ? req_wdata[DW +: DW] : req_wdata[0 +: DW];

  rr_arbiter2 u_arb (
    .clk    (clk),
    .rst    (rst),
    .req    (req_valid),
    .upd    (grant),
    .gnt    (gnt),
    .gnt_id (gnt_id)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:        if (|req_valid) state_nxt = (gnt_op == OP_WRITE) ? WRITE : READ;
      WRITE, READ: state_nxt = RESP;
      RESP:        state_nxt = IDLE;
      default:     state_nxt = IDLE;
    endcase
  end

  // Gated by rst so a write in flight never reaches the bank during reset.
  always_comb begin
    req_ready = '0;
    rf_ld     = '0;
    rsp_valid = '0;
    if (!rst) begin
      case (state)
        IDLE:    req_ready = gnt;
        WRITE:   rf_ld = addr_onehot(cur_addr);
        RESP:    rsp_valid[cur_g] = 1'b1;
        default: ;
      endcase
    end
  end

  // rf_d / rf_sel load at acceptance so they are stable for the whole op cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      cur_addr  <= '0;
      cur_g     <= 1'b0;
      rf_d      <= '0;
      rf_sel    <= '0;
      rsp_rdata <= '0;
    end else begin
      if (grant) begin
        cur_addr <= gnt_addr;
        cur_g    <= gnt_id;
        if (gnt_op == OP_WRITE) begin
          rf_d <= gnt_wdata;
        end else begin
          rf_sel <= gnt_addr;
        end
      end
      if (state == READ) begin
        rsp_rdata <= rf_q;
      end else if (state == WRITE) begin
        rsp_rdata <= '0;
      end
    end
  end

endmodule

// File: tb/tb_regbank_arbiter.sv
// Randomised bench for regbank_arbiter with a transaction-level reference model and bank model.
module tb_regbank_arbiter;

  typedef struct packed {
    logic       we;
    logic [1:0] addr;
    logic [7:0] wd;
  } tb_op_t;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  req_valid, req_ready, req_we, rsp_valid;
  logic [3:0]  req_addr, rf_ld;
  logic [15:0] req_wdata;
  logic [7:0]  rsp_rdata, rf_d, rf_q;
  logic [1:0]  rf_sel;
  logic [7:0]  bank [4];

  always #5 clk = ~clk;

  regbank_arbiter dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_we    (req_we),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .rsp_valid (rsp_valid),
    .rsp_rdata (rsp_rdata),
    .rf_ld     (rf_ld),
    .rf_d      (rf_d),
    .rf_sel    (rf_sel),
    .rf_q      (rf_q)
  );

  assign rf_q = bank[rf_sel];
  always @(posedge clk) begin
    for (int i = 0; i < 4; i++) if (rf_ld[i]) bank[i] <= rf_d;
  end

  int checks = 0, failures = 0, cyc = 0;
  tb_op_t q0[$], q1[$];
  tb_op_t cur[2];
  logic [1:0] cur_vld, acc;
  bit gaps;
  int m_phase, m_last, m_g;
  tb_op_t m_op;
  logic [7:0] m_mem [4];
  logic [7:0] exp_d;
  logic [1:0] exp_sel;
  logic [7:0] last_rdata [2];
  int rsp_cnt [2];
  int glog[$];

  function automatic tb_op_t mk(input logic we, input logic [1:0] a, input logic [7:0] d);
    tb_op_t o;
    o.we = we; o.addr = a; o.wd = d;
    return o;
  endfunction

  task automatic drive();
    req_valid = cur_vld;
    req_we    = {cur[1].we, cur[0].we};
    req_addr  = {cur[1].addr, cur[0].addr};
    req_wdata = {cur[1].wd, cur[0].wd};
  endtask

  task automatic model_reset();
    m_phase = 0; m_last = 1; exp_d = 8'h00; exp_sel = 2'd0;
    cur_vld = 2'b00; acc = 2'b00;
    drive();
  endtask

  // Compare one cycle of DUT outputs against the transaction model, then advance the model.
  task automatic check_cycle();
    logic [1:0] e_rdy, e_rsp;
    logic [3:0] e_ld;
    logic [7:0] e_data;
    int g;
    e_rdy = '0; e_rsp = '0; e_ld = '0; g = -1;
    if (m_phase == 0 && cur_vld != 2'b00) begin
`ifdef REGBANK_ARB_FIXED_PRIO_EN
      g = cur_vld[0] ? 0 : 1;
`else
      g = (cur_vld == 2'b11) ? 1 - m_last : (cur_vld[0] ? 0 : 1);
`endif
      e_rdy[g] = 1'b1;
    end else if (m_phase == 1) begin
      if (m_op.we) begin
        e_ld[m_op.addr] = 1'b1;
        exp_d = m_op.wd;
      end else begin
        exp_sel = m_op.addr;
      end
    end else if (m_phase == 2) begin
      e_rsp[m_g] = 1'b1;
    end
    checks++;
    if (req_ready !== e_rdy) begin
      failures++; $display("FAIL req_ready cyc=%0d got=%b exp=%b", cyc, req_ready, e_rdy);
    end
    checks++;
    if (rf_ld !== e_ld) begin
      failures++; $display("FAIL rf_ld cyc=%0d got=%b exp=%b", cyc, rf_ld, e_ld);
    end
    checks++;
    if (rsp_valid !== e_rsp) begin
      failures++; $display("FAIL rsp_valid cyc=%0d got=%b exp=%b", cyc, rsp_valid, e_rsp);
    end
    checks++;
    if (rf_d !== exp_d) begin
      failures++; $display("FAIL rf_d cyc=%0d got=%h exp=%h", cyc, rf_d, exp_d);
    end
    checks++;
    if (rf_sel !== exp_sel) begin
      failures++; $display("FAIL rf_sel cyc=%0d got=%0d exp=%0d", cyc, rf_sel, exp_sel);
    end
    if (m_phase == 2) begin
      e_data = m_op.we ? 8'h00 : m_mem[m_op.addr];
      checks++;
      if (rsp_rdata !== e_data) begin
        failures++; $display("FAIL rsp_rdata cyc=%0d got=%h exp=%h", cyc, rsp_rdata, e_data);
      end
      last_rdata[m_g] = rsp_rdata;
      rsp_cnt[m_g]++;
      if (m_op.we) m_mem[m_op.addr] = m_op.wd;
      m_phase = 0;
    end else if (m_phase == 1) begin
      m_phase = 2;
    end else if (g >= 0) begin
      m_last = g; m_g = g; m_op = cur[g]; acc[g] = 1'b1;
      glog.push_back(g);
      m_phase = 1;
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
    for (int i = 0; i < 2; i++) begin
      if (acc[i]) begin cur_vld[i] = 1'b0; acc[i] = 1'b0; end
    end
    if (!cur_vld[0] && q0.size() > 0 && (!gaps || $urandom_range(3) != 0)) begin
      cur[0] = q0.pop_front(); cur_vld[0] = 1'b1;
    end
    if (!cur_vld[1] && q1.size() > 0 && (!gaps || $urandom_range(3) != 0)) begin
      cur[1] = q1.pop_front(); cur_vld[1] = 1'b1;
    end
    drive();
    @(negedge clk);
    check_cycle();
  endtask

  task automatic drain(input int budget);
    int n = 0;
    while ((q0.size() > 0 || q1.size() > 0 || cur_vld != 2'b00 || m_phase != 0) && n < budget) begin
      step(); n++;
    end
    checks++;
    if (n >= budget) begin
      failures++; $display("FAIL drain_timeout cyc=%0d got=%0d cycles exp<%0d", cyc, n, budget);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    cur[0] = mk(1'b1, 2'($urandom), 8'($urandom));
    cur[1] = mk(1'b0, 2'($urandom), 8'($urandom));
    cur_vld = 2'b11; acc = 2'b00;
    drive();
    @(negedge clk);
    checks++;
    if (req_ready !== 2'b00 || rf_ld !== 4'h0 || rsp_valid !== 2'b00) begin
      failures++; $display("FAIL reset_strobes got=%b/%b/%b exp=00/0000/00", req_ready, rf_ld, rsp_valid);
    end
    checks++;
    if (rsp_rdata !== 8'h00 || rf_d !== 8'h00 || rf_sel !== 2'd0) begin
      failures++; $display("FAIL reset_data got=%h/%h/%0d exp=00/00/0", rsp_rdata, rf_d, rf_sel);
    end
    @(posedge clk); #1;
    cur_vld = 2'b00; drive();
    @(posedge clk); #1;
    rst = 1'b0;
    model_reset();
    repeat (3) step();
    checks++;
    if (rsp_rdata !== 8'h00) begin
      failures++; $display("FAIL idle_rdata got=%h exp=00", rsp_rdata);
    end
  endtask

  task automatic test_single();
    int c0 = rsp_cnt[0];
    q0.push_back(mk(1'b1, 2'd2, 8'hA5));
    q0.push_back(mk(1'b0, 2'd2, 8'h00));
    drain(40);
    checks++;
    if (last_rdata[0] !== 8'hA5) begin
      failures++; $display("FAIL single_read got=%h exp=a5", last_rdata[0]);
    end
    checks++;
    if (rsp_cnt[0] - c0 != 2) begin
      failures++; $display("FAIL single_rsp_count got=%0d exp=2", rsp_cnt[0] - c0);
    end
  endtask

  task automatic test_contention();
    int base = glog.size();
    int first = 1 - m_last;
    int c1 = rsp_cnt[1];
    int e;
    gaps = 1'b0;
    repeat (3) q0.push_back(mk(1'b1, 2'd0, 8'h11));
    repeat (3) q1.push_back(mk(1'b1, 2'd1, 8'h22));
    drain(80);
    for (int k = 0; k < 6; k++) begin
`ifdef REGBANK_ARB_FIXED_PRIO_EN
      e = (k < 3) ? 0 : 1;
`else
      e = (k % 2 == 0) ? first : 1 - first;
`endif
      checks++;
      if (base + k >= glog.size() || glog[base + k] != e) begin
        failures++; $display("FAIL contention_grant k=%0d got=%0d exp=%0d", k,
                             (base + k < glog.size()) ? glog[base + k] : -1, e);
      end
    end
    checks++;
    if (rsp_cnt[1] - c1 != 3) begin
      failures++; $display("FAIL contention_rsp1 got=%0d exp=3", rsp_cnt[1] - c1);
    end
  endtask

  task automatic test_hazard();
    q1.push_back(mk(1'b1, 2'd3, 8'h3C));
    drain(20);
    q0.push_back(mk(1'b0, 2'd3, 8'h00));
    drain(20);
    checks++;
    if (last_rdata[0] !== 8'h3C) begin
      failures++; $display("FAIL hazard_read got=%h exp=3c", last_rdata[0]);
    end
  endtask

  task automatic test_reset_midop();
    int n = 0;
    q0.push_back(mk(1'b1, 2'd1, 8'hFF));
    while (m_phase != 1 && n < 10) begin step(); n++; end
    checks++;
    if (m_phase != 1) begin
      failures++; $display("FAIL midop_accept got=phase%0d exp=phase1", m_phase);
    end
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if (rf_ld !== 4'h0 || rsp_valid !== 2'b00 || req_ready !== 2'b00) begin
      failures++; $display("FAIL midop_strobes got=%b/%b/%b exp=0000/00/00", rf_ld, rsp_valid, req_ready);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    model_reset();
    repeat (4) step();
    checks++;
    if (rsp_rdata !== 8'h00) begin
      failures++; $display("FAIL midop_rdata_cleared got=%h exp=00", rsp_rdata);
    end
    q0.push_back(mk(1'b0, 2'd1, 8'h00));
    drain(20);
    checks++;
    if (last_rdata[0] !== 8'h22) begin
      failures++; $display("FAIL midop_read got=%h exp=22", last_rdata[0]);
    end
  endtask

  task automatic test_back_to_back();
    logic [1:0] pat [4];
    pat[0] = 2'b01; pat[1] = 2'b00; pat[2] = 2'b00; pat[3] = 2'b10;
    q0.push_back(mk(1'b1, 2'd0, 8'($urandom)));
    for (int k = 0; k < 4; k++) begin
      step();
      if (k == 0) q1.push_back(mk(1'b0, 2'd2, 8'h00));
      checks++;
      if (req_ready !== pat[k]) begin
        failures++; $display("FAIL backpressure_ready k=%0d got=%b exp=%b", k, req_ready, pat[k]);
      end
    end
    drain(20);
    checks++;
    if (last_rdata[1] !== 8'hA5) begin
      failures++; $display("FAIL backpressure_read got=%h exp=a5", last_rdata[1]);
    end
  endtask

  task automatic test_random();
    gaps = 1'b1;
    for (int k = 0; k < 30; k++) begin
      q0.push_back(mk(1'($urandom), 2'($urandom), 8'($urandom)));
      q1.push_back(mk(1'($urandom), 2'($urandom), 8'($urandom)));
    end
    drain(2000);
    gaps = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 4; i++) begin bank[i] = 8'h00; m_mem[i] = 8'h00; end
    rsp_cnt[0] = 0; rsp_cnt[1] = 0;
    last_rdata[0] = 8'h00; last_rdata[1] = 8'h00;
    gaps = 1'b0;
    m_op = mk(1'b0, 2'd0, 8'h00); m_g = 0;
    model_reset();
    test_reset();
    test_single();
    test_contention();
    test_hazard();
    test_reset_midop();
    test_back_to_back();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog expired at cyc=%0d", cyc);
    $fatal(1, "watchdog");
  end

endmodule
